// File: rtl/crd_slip_scheduler.sv
// Elastic bit buffer between the CRD and the NRZI decoder: absorbs ADD/DROP slips,
// sequences start-up fill, and declares or drops lock on slip rate, overflow and underflow.
module crd_slip_scheduler #(
    parameter int DEPTH       = 8,
    parameter int START_LEVEL = 4,
    parameter int WINDOW      = 64,
    parameter int MAX_SLIPS   = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic [1:0]             in_bits,
    input  logic                   in_add,
    input  logic                   in_drop,
    output logic                   out_bit,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [$clog2(DEPTH):0] level,
    output logic                   locked,
    output logic                   overflow,
    output logic                   underflow,
    output logic                   slip_err,
    output logic                   proto_err
);

    localparam int AW         = $clog2(DEPTH);
    localparam int LW         = AW + 1;
    localparam int SPW        = AW + 2;
    localparam int WW         = (WINDOW > 1) ? $clog2(WINDOW) : 1;
    localparam int SW         = $clog2(MAX_SLIPS + 2);
    localparam int WIN_LAST_I = WINDOW - 1;
    localparam int SLIP_SAT_I = MAX_SLIPS + 1;

    localparam logic [SPW-1:0] DEPTH_W  = SPW'(DEPTH);
    localparam logic [LW-1:0]  START_W  = LW'(START_LEVEL);
    localparam logic [WW-1:0]  WIN_LAST = WW'(WIN_LAST_I);
    localparam logic [SW-1:0]  SLIP_MAX = SW'(MAX_SLIPS);
    localparam logic [SW-1:0]  SLIP_SAT = SW'(SLIP_SAT_I);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_FILL  = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_FLUSH = 2'd3;

    logic [1:0]    r_state;
    logic [LW-1:0] r_level;
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic          r_mem [DEPTH];
    logic [WW-1:0] r_win;
    logic [SW-1:0] r_slips;
    logic          r_overflow;
    logic          r_underflow;
    logic          r_slip_err;
    logic          r_proto_err;

    logic [1:0]     w_state_next;
    logic           w_accept;
    logic [1:0]     w_wr_req;
    logic [1:0]     w_wr_cnt;
    logic           w_first_bit;
    logic           w_proto;
    logic           w_out_valid;
    logic           w_rd;
    logic [SPW-1:0] w_space;
    logic           w_ovf_hit;
    logic           w_unf_hit;
    logic [LW-1:0]  w_level_next;
    logic           w_mon_active;
    logic           w_slip_event;
    logic           w_win_wrap;
    logic           w_slip_hit;
    logic [AW-1:0]  w_wr_ptr_p1;

    assign w_accept    = in_valid && (r_state != S_FLUSH);
    assign w_proto     = w_accept && in_add && in_drop;
    assign w_out_valid = (r_state == S_RUN) && (r_level != '0);
    assign w_rd        = w_out_valid && out_ready;

    always_comb begin
        w_wr_req = 2'd0;
        if (w_accept) begin
            if (in_add && !in_drop)
                w_wr_req = 2'd2;
            else if (in_drop && !in_add)
                w_wr_req = 2'd0;
            else
                w_wr_req = 2'd1;
        end
    end

    // Free space counts the slot vacated by a same-cycle read; excess bits are dropped in order.
    assign w_space      = DEPTH_W - SPW'(r_level) + SPW'(w_rd);
    assign w_ovf_hit    = SPW'(w_wr_req) > w_space;
    assign w_wr_cnt     = w_ovf_hit ? w_space[1:0] : w_wr_req;
    assign w_first_bit  = (w_wr_req == 2'd2) ? in_bits[1] : in_bits[0];
    assign w_level_next = r_level + LW'(w_wr_cnt) - LW'(w_rd);
    assign w_unf_hit    = (r_state == S_RUN) && (r_level == '0) && out_ready;
    assign w_wr_ptr_p1  = r_wr_ptr + AW'(1);

    assign w_mon_active = (r_state == S_FILL) || (r_state == S_RUN);
    assign w_slip_event = w_mon_active && in_valid && (in_add || in_drop);
    assign w_win_wrap   = (r_win == WIN_LAST);
    assign w_slip_hit   = w_slip_event && !w_win_wrap && (r_slips == SLIP_MAX);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:  if (in_valid) w_state_next = S_FILL;
            S_FILL: begin
                if (w_ovf_hit || w_slip_hit)
                    w_state_next = S_FLUSH;
                else if (w_level_next >= START_W)
                    w_state_next = S_RUN;
            end
            S_RUN:   if (w_ovf_hit || w_unf_hit || w_slip_hit) w_state_next = S_FLUSH;
            S_FLUSH: w_state_next = S_FILL;
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_level     <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
            r_slip_err  <= 1'b0;
            r_proto_err <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_overflow  <= w_ovf_hit;
            r_underflow <= w_unf_hit;
            r_slip_err  <= w_slip_hit;
            r_proto_err <= w_proto;
            if (w_state_next == S_FLUSH) begin
                r_level  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                r_level  <= w_level_next;
                r_wr_ptr <= r_wr_ptr + AW'(w_wr_cnt);
                r_rd_ptr <= r_rd_ptr + AW'(w_rd);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (w_wr_cnt != 2'd0)
            r_mem[r_wr_ptr] <= w_first_bit;
        if (w_wr_cnt == 2'd2)
            r_mem[w_wr_ptr_p1] <= in_bits[0];
    end

    // A slip landing on the wrap cycle opens the new window with a count of one.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_win   <= '0;
            r_slips <= '0;
        end else if (!w_mon_active) begin
            r_win   <= '0;
            r_slips <= '0;
        end else if (w_win_wrap) begin
            r_win   <= '0;
            r_slips <= w_slip_event ? SW'(1) : '0;
        end else begin
            r_win <= r_win + WW'(1);
            if (w_slip_event && (r_slips != SLIP_SAT))
                r_slips <= r_slips + SW'(1);
        end
    end

    assign out_valid = w_out_valid;
    assign out_bit   = w_out_valid & r_mem[r_rd_ptr];
    assign level     = r_level;
    assign locked    = (r_state == S_RUN);
    assign overflow  = r_overflow;
    assign underflow = r_underflow;
    assign slip_err  = r_slip_err;
    assign proto_err = r_proto_err;

endmodule

// File: tb/tb_crd_slip_scheduler.sv
// Directed bench for crd_slip_scheduler: inputs change and outputs are sampled on the
// falling edge, so each applyStimulus call covers exactly one rising edge.
module tb_crd_slip_scheduler;

    logic       clock = 1'b0;
    logic       resetN = 1'b0;
    logic       inValid = 1'b0;
    logic [1:0] inBits = 2'b00;
    logic       inAdd = 1'b0;
    logic       inDrop = 1'b0;
    logic       outReady = 1'b0;
    logic       outBit;
    logic       outValid;
    logic [3:0] level;
    logic       locked;
    logic       overflow;
    logic       underflow;
    logic       slipErr;
    logic       protoErr;

    int nAssert = 0;
    int nFail = 0;

    crd_slip_scheduler #(.DEPTH(8), .START_LEVEL(4), .WINDOW(64), .MAX_SLIPS(8)) dut (
        .clock(clock), .reset(resetN), .in_valid(inValid), .in_bits(inBits),
        .in_add(inAdd), .in_drop(inDrop), .out_bit(outBit), .out_valid(outValid),
        .out_ready(outReady), .level(level), .locked(locked), .overflow(overflow),
        .underflow(underflow), .slip_err(slipErr), .proto_err(protoErr)
    );

    always #5 clock = ~clock;

    task automatic applyStimulus(input logic v, input logic [1:0] b, input logic add,
                                 input logic drop, input logic rdy);
        inValid  = v;
        inBits   = b;
        inAdd    = add;
        inDrop   = drop;
        outReady = rdy;
        @(negedge clock);
    endtask

    task automatic test_reset();
        @(negedge clock);
        nAssert++; if (level !== 4'd0) begin nFail++; $display("[TB] FAIL reset_level got %0d want 0", level); end
        nAssert++; if ({locked, outValid, outBit} !== 3'b000) begin nFail++; $display("[TB] FAIL reset_lock_valid_bit got %b want 000", {locked, outValid, outBit}); end
        nAssert++; if ({overflow, underflow, slipErr, protoErr} !== 4'b0000) begin nFail++; $display("[TB] FAIL reset_flags got %b want 0000", {overflow, underflow, slipErr, protoErr}); end
        resetN = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        nAssert++; if ({locked, level} !== 5'd0) begin nFail++; $display("[TB] FAIL idle_after_release got lock=%b level=%0d want 0/0", locked, level); end
    endtask

    task automatic test_fill();
        logic fillBits [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic nextBits [4] = '{1'b0, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, {1'b0, fillBits[i]}, 1'b0, 1'b0, 1'b1);
            nAssert++; if (level !== 4'(i + 1)) begin nFail++; $display("[TB] FAIL fill_level[%0d] got %0d want %0d", i, level, i + 1); end
            nAssert++; if (locked !== (i == 3)) begin nFail++; $display("[TB] FAIL fill_locked[%0d] got %b want %b", i, locked, (i == 3)); end
        end
        for (int k = 0; k < 4; k++) begin
            nAssert++; if ({outValid, outBit} !== {1'b1, fillBits[k]}) begin nFail++; $display("[TB] FAIL stream_bit[%0d] got v=%b b=%b want v=1 b=%b", k, outValid, outBit, fillBits[k]); end
            nAssert++; if (level !== 4'd4) begin nFail++; $display("[TB] FAIL stream_level[%0d] got %0d want 4", k, level); end
            applyStimulus(1'b1, {1'b0, nextBits[k]}, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_add_drop();
        logic expBits [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        nAssert++; if (outBit !== 1'b0) begin nFail++; $display("[TB] FAIL pre_add_head got %b want 0", outBit); end
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b1);
        nAssert++; if (level !== 4'd5) begin nFail++; $display("[TB] FAIL add_level got %0d want 5", level); end
        nAssert++; if ({overflow, underflow, slipErr, protoErr} !== 4'b0000) begin nFail++; $display("[TB] FAIL add_flags got %b want 0000", {overflow, underflow, slipErr, protoErr}); end
        applyStimulus(1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        nAssert++; if (level !== 4'd4) begin nFail++; $display("[TB] FAIL drop_level got %0d want 4", level); end
        for (int k = 0; k < 4; k++) begin
            nAssert++; if ({outBit, level} !== {expBits[k], 4'd4}) begin nFail++; $display("[TB] FAIL slip_stream[%0d] got b=%b l=%0d want b=%b l=4", k, outBit, level, expBits[k]); end
            nAssert++; if ({overflow, underflow, slipErr, protoErr, locked} !== 5'b00001) begin nFail++; $display("[TB] FAIL slip_stream_flags[%0d] got %b want 00001", k, {overflow, underflow, slipErr, protoErr, locked}); end
            applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        end
    endtask

    task automatic test_overflow();
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        nAssert++; if ({level, overflow, locked} !== {4'd6, 1'b0, 1'b1}) begin nFail++; $display("[TB] FAIL ovf_add1 got l=%0d o=%b k=%b want 6/0/1", level, overflow, locked); end
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        nAssert++; if ({level, overflow, locked} !== {4'd8, 1'b0, 1'b1}) begin nFail++; $display("[TB] FAIL ovf_add2 got l=%0d o=%b k=%b want 8/0/1", level, overflow, locked); end
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        nAssert++; if ({level, overflow, locked, outValid} !== {4'd0, 1'b1, 1'b0, 1'b0}) begin nFail++; $display("[TB] FAIL ovf_pulse got l=%0d o=%b k=%b v=%b want 0/1/0/0", level, overflow, locked, outValid); end
        applyStimulus(1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        nAssert++; if ({level, overflow, locked} !== {4'd0, 1'b0, 1'b0}) begin nFail++; $display("[TB] FAIL ovf_flush_discard got l=%0d o=%b k=%b want 0/0/0", level, overflow, locked); end
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        nAssert++; if ({level, locked} !== {4'd0, 1'b0}) begin nFail++; $display("[TB] FAIL ovf_refill got l=%0d k=%b want 0/0", level, locked); end
    endtask

    task automatic test_underflow();
        logic fillBits [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, {1'b0, fillBits[i]}, 1'b0, 1'b0, 1'b0);
        nAssert++; if ({level, locked} !== {4'd4, 1'b1}) begin nFail++; $display("[TB] FAIL unf_relock got l=%0d k=%b want 4/1", level, locked); end
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        nAssert++; if ({level, outValid, outBit} !== {4'd2, 1'b1, 1'b0}) begin nFail++; $display("[TB] FAIL unf_lvl2 got l=%0d v=%b b=%b want 2/1/0", level, outValid, outBit); end
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        nAssert++; if ({level, outValid, outBit} !== {4'd1, 1'b1, 1'b1}) begin nFail++; $display("[TB] FAIL unf_lvl1 got l=%0d v=%b b=%b want 1/1/1", level, outValid, outBit); end
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        nAssert++; if ({level, outValid, locked, underflow} !== {4'd0, 1'b0, 1'b1, 1'b0}) begin nFail++; $display("[TB] FAIL unf_empty got l=%0d v=%b k=%b u=%b want 0/0/1/0", level, outValid, locked, underflow); end
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        nAssert++; if ({underflow, locked} !== 2'b10) begin nFail++; $display("[TB] FAIL unf_pulse got u=%b k=%b want 1/0", underflow, locked); end
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        nAssert++; if ({underflow, locked} !== 2'b00) begin nFail++; $display("[TB] FAIL unf_one_cycle got u=%b k=%b want 0/0", underflow, locked); end
    endtask

    task automatic test_proto_err();
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 2'b01, 1'b1, 1'b1, 1'b0);
        nAssert++; if ({protoErr, level, overflow} !== {1'b1, 4'd5, 1'b0}) begin nFail++; $display("[TB] FAIL proto_pulse got p=%b l=%0d o=%b want 1/5/0", protoErr, level, overflow); end
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
            nAssert++; if (protoErr !== 1'b0) begin nFail++; $display("[TB] FAIL proto_one_cycle[%0d] got %b want 0", k, protoErr); end
        end
        nAssert++; if ({level, outBit} !== {4'd1, 1'b1}) begin nFail++; $display("[TB] FAIL proto_bit got l=%0d b=%b want 1/1", level, outBit); end
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic runSlipBurst(input int nEvents, input string tag);
        logic add;
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
        nAssert++; if ({level, locked} !== {4'd4, 1'b1}) begin nFail++; $display("[TB] FAIL %s_lock got l=%0d k=%b want 4/1", tag, level, locked); end
        for (int e = 0; e < nEvents; e++) begin
            add = (e % 2 == 0);
            applyStimulus(1'b1, 2'b10, add, !add, 1'b1);
            if (e < 8) begin
                nAssert++; if ({slipErr, locked, level} !== {1'b0, 1'b1, (add ? 4'd5 : 4'd4)}) begin nFail++; $display("[TB] FAIL %s_event[%0d] got s=%b k=%b l=%0d want 0/1/%0d", tag, e, slipErr, locked, level, (add ? 5 : 4)); end
            end else begin
                nAssert++; if ({slipErr, locked, level} !== {1'b1, 1'b0, 4'd0}) begin nFail++; $display("[TB] FAIL %s_slip_err got s=%b k=%b l=%0d want 1/0/0", tag, slipErr, locked, level); end
            end
        end
    endtask

    task automatic test_slip_limit();
        runSlipBurst(9, "slip9");
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        nAssert++; if (slipErr !== 1'b0) begin nFail++; $display("[TB] FAIL slip9_one_cycle got %b want 0", slipErr); end
        runSlipBurst(8, "slip8");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b1);
            nAssert++; if ({slipErr, locked, level} !== {1'b0, 1'b1, 4'd4}) begin nFail++; $display("[TB] FAIL slip8_hold[%0d] got s=%b k=%b l=%0d want 0/1/4", k, slipErr, locked, level); end
        end
    endtask

    task automatic test_reset_mid_run();
        resetN = 1'b0;
        #1;
        nAssert++; if ({level, locked, outValid, outBit} !== 7'd0) begin nFail++; $display("[TB] FAIL midrst_outputs got l=%0d k=%b v=%b b=%b want all 0", level, locked, outValid, outBit); end
        nAssert++; if ({overflow, underflow, slipErr, protoErr} !== 4'b0000) begin nFail++; $display("[TB] FAIL midrst_flags got %b want 0000", {overflow, underflow, slipErr, protoErr}); end
        @(negedge clock);
        resetN = 1'b1;
        applyStimulus(1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
        nAssert++; if ({level, locked, outValid} !== 6'd0) begin nFail++; $display("[TB] FAIL midrst_idle got l=%0d k=%b v=%b want 0/0/0", level, locked, outValid); end
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
            nAssert++; if ({level, locked} !== {4'(i + 1), (i == 3)}) begin nFail++; $display("[TB] FAIL midrst_refill[%0d] got l=%0d k=%b want %0d/%b", i, level, locked, i + 1, (i == 3)); end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_add_drop();
        test_overflow();
        test_underflow();
        test_proto_err();
        test_slip_limit();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule

// File: doc/crd_slip_scheduler.md
Name: crd_slip_scheduler

Overview:
- Sits between the CRD block and the USB2 NRZI decoder in the data-recovery path.
- The CRD recovers 0, 1 or 2 bits per clock. It signals DROP when no bit was recovered and ADD when two bits were recovered.
- This block absorbs those slips in a small elastic bit buffer and presents a steady one-bit-per-handshake stream downstream.
- It sequences start-up (fill to half depth before releasing data) and monitors slip rate, overflow and underflow to declare and lose lock.

Parameters:
- DEPTH, 8: elastic buffer depth in bits; power of two, minimum 4.
- START_LEVEL, 4: fill level required before streaming begins.
- WINDOW, 64: slip-monitor window length in clock cycles.
- MAX_SLIPS, 8: maximum ADD plus DROP events allowed per window.

Ports:
- clock  input  1  block clock.
- reset  input  1  asynchronous, active-low reset (asserted at 0).
- in_valid  input  1  CRD output valid this cycle.
- in_bits  input  2  recovered bits; in_bits[0] is the normal bit, in_bits[1] is the earlier bit on ADD.
- in_add  input  1  CRD ADD: two bits this cycle.
- in_drop  input  1  CRD DROP: no bit this cycle.
- out_bit  output  1  head-of-buffer bit.
- out_valid  output  1  out_bit valid.
- out_ready  input  1  downstream accepts out_bit.
- level  output  $clog2(DEPTH)+1  current fill level.
- locked  output  1  high in RUN.
- overflow  output  1  one-cycle pulse.
- underflow  output  1  one-cycle pulse.
- slip_err  output  1  one-cycle pulse.
- proto_err  output  1  one-cycle pulse: in_add and in_drop high together.

Behaviour:
- Reset (asynchronous, reset==0):
  - state=IDLE.
  - level, read/write pointers, slip counter and window counter = 0.
  - All outputs 0.
  - Reset asserted mid-operation discards buffer contents immediately.
- Write count wr per cycle:
  - !in_valid -> 0.
  - in_drop only -> 0.
  - in_add only -> 2; write in_bits[1] first, then in_bits[0].
  - neither -> 1; write in_bits[0].
  - in_add and in_drop both high -> 1 (in_bits[0]), and proto_err pulses.
- Read: rd = out_valid & out_ready.
  - out_bit is the buffer head.
  - A bit written in cycle N is readable no earlier than cycle N+1.
- Level update: level_next = level + wr - rd. Reads and writes in the same cycle are both honoured.
- Overflow: if level - rd + wr > DEPTH, write only the bits that fit, in order. Pulse overflow next cycle and go to FLUSH.
- States:
  - IDLE: out_valid=0. Go to FILL on the first in_valid.
  - FILL: out_valid=0; writes accepted. Go to RUN when level_next >= START_LEVEL.
  - RUN: out_valid = (level != 0); locked=1.
    - level==0 with out_ready high -> underflow pulse, go to FLUSH.
    - slip_err -> FLUSH.
    - overflow -> FLUSH.
  - FLUSH: one cycle. out_valid=0; pointers and level cleared; inputs that cycle discarded. Go to FILL.
- Slip monitor (active in FILL and RUN):
  - Window counter wraps at WINDOW-1.
  - Slip counter increments on each in_valid cycle with in_add or in_drop; saturates at MAX_SLIPS+1.
  - When the count exceeds MAX_SLIPS, slip_err pulses once and the counter holds until the window wraps.
  - On wrap, the counter clears; a slip in the wrap cycle counts toward the new window.
  - Cleared in IDLE and FLUSH.
- Pointers wrap modulo DEPTH. level ranges 0..DEPTH inclusive.
- All status pulses are registered: high exactly one cycle after the triggering event.

Test Plan:
1. Reset, then 4 in_valid plain cycles with in_bits[0] = 1,0,1,1 and out_ready=1 -> stays in FILL for 4 cycles; locked=1 in the cycle level reaches 4; out_bit sequence 1,0,1,1 while level holds at 4 with continued input.
2. In RUN at level 4: one ADD cycle (in_bits=2'b10) then one DROP cycle, with out_ready=1 throughout -> level goes 4 -> 5 -> 4; stream shows 1 then 0 in order; no error flags.
3. out_ready=0 with continuous ADD from level 4 -> level 6, 8, then the third ADD overflows: overflow pulse, FLUSH for one cycle, level=0, locked=0, state FILL.
4. In RUN, in_valid=0 and out_ready=1 from level 2 -> 2 bits delivered, then underflow pulse, FLUSH, FILL.
5. 9 ADD/DROP events inside one 64-cycle window while in RUN -> slip_err pulses after the 9th event and block enters FLUSH. Repeat with 8 events -> no slip_err.
6. in_add=in_drop=1 with in_bits=2'b01 -> proto_err pulse, exactly one bit (1) written. Then assert reset=0 mid-RUN -> all outputs 0 immediately, state IDLE on release.
